// File: rtl/mips_muldiv_unit_if.sv
// Control-path bundle for the HI/LO multiply/divide unit: start/busy/done
// handshake, operands, MTHI/MTLO write port and HI/LO read-back.
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] ina;
    logic [WIDTH-1:0] inb;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, ina, inb, wr_hi, wr_lo, wdata,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, ina, inb, wr_hi, wr_lo, wdata,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one radix-2 step per clock.
// Define MULDIV_EARLY_OUT_EN to finish multiplies once the remaining multiplier bits are zero.
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    mips_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           op_reg;
    logic                 prod_neg;
    logic                 rem_neg;
    logic                 fin_hold;
    logic                 dz_reg;
    logic                 done_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplr;

    logic                 start_ok;
    logic                 dz_start;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   mul_sum;
    logic [WIDTH-1:0]     mplr_shift;
    logic [WIDTH:0]       rem_sh;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_sub;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     fin_hi;
    logic [WIDTH-1:0]     fin_lo;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    assign start_ok = (state == IDLE) && bus.start;
    assign dz_start = start_ok && bus.op[1] && (bus.inb == '0);
    assign mag_a    = neg_w(bus.ina, bus.op[0] & bus.ina[WIDTH-1]);
    assign mag_b    = neg_w(bus.inb, bus.op[0] & bus.inb[WIDTH-1]);

    // Multiply: shift-add with the multiplicand walking left, multiplier right.
    assign mul_sum    = acc + (mplr[0] ? mcand : '0);
    assign mplr_shift = mplr >> 1;

    // Divide: acc holds {remainder, dividend/quotient}; restoring step.
    assign rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign q_bit    = rem_sh >= {1'b0, mcand[WIDTH-1:0]};
    assign rem_sub  = rem_sh[WIDTH-1:0] - mcand[WIDTH-1:0];
    assign div_next = {(q_bit ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};

    assign prod_fix = neg_2w(acc, prod_neg);

    always_comb begin
        fin_hi = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo = prod_fix[WIDTH-1:0];
        if (dz_reg) begin
            fin_hi = acc[2*WIDTH-1:WIDTH];
            fin_lo = '1;
        end else if (op_reg[1]) begin
            fin_hi = neg_w(acc[2*WIDTH-1:WIDTH], rem_neg);
            fin_lo = neg_w(acc[WIDTH-1:0], prod_neg);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = dz_start ? FIN : RUN;
            RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIN;
`ifdef MULDIV_EARLY_OUT_EN
                else if (!op_reg[1] && (mplr_shift == '0)) state_nxt = FIN;
`endif
            end
            FIN: if (!fin_hold) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            cnt      <= '0;
            done_reg <= 1'b0;
            dz_reg   <= 1'b0;
            fin_hold <= 1'b0;
            hi_reg   <= '0;
            lo_reg   <= '0;
        end else begin
            state    <= state_nxt;
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt      <= '0;
                        dz_reg   <= dz_start;
                        fin_hold <= dz_start;
                    end else begin
                        if (bus.wr_hi) hi_reg <= bus.wdata;
                        if (bus.wr_lo) lo_reg <= bus.wdata;
                    end
                end
                RUN: cnt <= cnt + CNT_W'(1);
                FIN: begin
                    // Zero-divisor results spend one extra cycle in FIN.
                    if (fin_hold) begin
                        fin_hold <= 1'b0;
                    end else begin
                        hi_reg   <= fin_hi;
                        lo_reg   <= fin_lo;
                        done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (start_ok) begin
            op_reg   <= bus.op;
            prod_neg <= bus.op[0] & (bus.ina[WIDTH-1] ^ bus.inb[WIDTH-1]);
            rem_neg  <= bus.op[0] & bus.ina[WIDTH-1];
            mplr     <= mag_b;
            if (bus.op[1]) begin
                acc   <= dz_start ? {bus.ina, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, mag_a};
                mcand <= {{WIDTH{1'b0}}, mag_b};
            end else begin
                acc   <= '0;
                mcand <= {{WIDTH{1'b0}}, mag_a};
            end
        end else if (state == RUN) begin
            if (op_reg[1]) begin
                acc <= div_next;
            end else begin
                acc   <= mul_sum;
                mcand <= mcand << 1;
                mplr  <= mplr_shift;
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.div_zero = dz_reg;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: directed vectors push expected HI/LO and done cycle,
// a negedge monitor compares them whenever done pulses.
module tb_mips_muldiv_unit;
    localparam int W = 32;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    mips_muldiv_unit_if #(.WIDTH(W)) bus();

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (RST_N === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("result_hi", bus.hi, e.hi);
                check("result_lo", bus.lo, e.lo);
                check("result_div_zero", bus.div_zero, e.dz);
                check("done_cycle", cyc, e.cyc);
                check("busy_at_done", bus.busy, 1'b0);
            end
        end
    end

    function automatic int mul_lat(input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        int msb = 0;
        for (int i = 0; i < W; i++) if (b[i]) msb = i;
        return msb + 2;
`else
        return W + 1;
`endif
    endfunction

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz,
                         input int lat, input bit expect_it);
        bus.start = 1'b1;
        bus.op    = op;
        bus.ina   = a;
        bus.inb   = b;
        if (expect_it) sb.push_back('{hi: eh, lo: el, dz: edz, cyc: cyc + 1 + lat});
        @(negedge CLK);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cnt);
        bit seen = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (bus.done === 1'b1) seen = 1'b1;
            else begin
                if (bus.busy === 1'b1) busy_cnt++;
                @(negedge CLK);
            end
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bc;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.ina   = '0;
        bus.inb   = '0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = '0;
        RST_N     = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_hi", bus.hi, 32'h0);
        check("reset_lo", bus.lo, 32'h0);
        check("reset_div_zero", bus.div_zero, 1'b0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Full-width unsigned multiply and busy window.
        issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0,
              mul_lat(32'hFFFFFFFF), 1'b1);
        wait_done(bc);
        check("multu_busy_cycles", bc, W + 1);

        // Signed multiply issued in the done cycle.
        issue(2'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, mul_lat(32'd5), 1'b1);
        wait_done(bc);

        issue(2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W + 1, 1'b1);
        wait_done(bc);
        @(negedge CLK);
        issue(2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, W + 1, 1'b1);
        wait_done(bc);

        // Zero divisor shortcut, then a valid divide clears the flag.
        @(negedge CLK);
        issue(2'd2, 32'h64, 32'h0, 32'h64, 32'hFFFFFFFF, 1'b1, 2, 1'b1);
        wait_done(bc);
        check("divzero_busy_cycles", bc, 2);
        @(negedge CLK);
        issue(2'd3, 32'd20, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFFA, 1'b0, W + 1, 1'b1);
        check("div_zero_cleared", bus.div_zero, 1'b0);
        wait_done(bc);

        // start and MTLO while busy are both ignored.
        @(negedge CLK);
        issue(2'd0, 32'h12345678, 32'h80000001, 32'h091A2B3C, 32'h12345678, 1'b0,
              mul_lat(32'h80000001), 1'b1);
        repeat (4) @(negedge CLK);
        bus.start = 1'b1;
        bus.op    = 2'd2;
        bus.ina   = 32'd5;
        bus.inb   = 32'd0;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h1234;
        @(negedge CLK);
        bus.start = 1'b0;
        bus.wr_lo = 1'b0;
        check("busy_ignores_wr_lo", bus.lo, 32'hFFFFFFFA);
        check("busy_ignores_start", bus.div_zero, 1'b0);
        check("busy_mid_op", bus.busy, 1'b1);
        wait_done(bc);

        // MTLO, then MTHI+MTLO together in IDLE.
        @(negedge CLK);
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h1234;
        @(negedge CLK);
        bus.wr_lo = 1'b0;
        check("mtlo_lo", bus.lo, 32'h1234);
        check("mtlo_hi_kept", bus.hi, 32'h091A2B3C);
        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'hABCD;
        @(negedge CLK);
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        check("mthi_both_hi", bus.hi, 32'hABCD);
        check("mtlo_both_lo", bus.lo, 32'hABCD);

        // start wins over MTHI in the same cycle.
        bus.wr_hi = 1'b1;
        bus.wdata = 32'hDEAD;
        issue(2'd0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, mul_lat(32'd4), 1'b1);
        bus.wr_hi = 1'b0;
        check("start_beats_mthi", bus.hi, 32'hABCD);
        wait_done(bc);

        // Reset in the middle of a divide.
        @(negedge CLK);
        issue(2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        repeat (9) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        check("midreset_busy", bus.busy, 1'b0);
        check("midreset_done", bus.done, 1'b0);
        check("midreset_hi", bus.hi, 32'h0);
        check("midreset_lo", bus.lo, 32'h0);
        RST_N = 1'b1;
        @(negedge CLK);
        issue(2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, W + 1, 1'b1);
        wait_done(bc);
        check("post_reset_busy_cycles", bc, W + 1);

        repeat (3) @(negedge CLK);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath, parametrised in operand width.
- Sits beside the single-cycle ALU and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, using a start/busy/done handshake to the control path.
- Also provides the MTHI/MTLO write path.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO. Must be ≥4.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation select: 0=MULTU, 1=MULT, 2=DIVU, 3=DIV.
- ina  input  WIDTH  rs operand (multiplicand / dividend).
- inb  input  WIDTH  rt operand (multiplier / divisor).
- wr_hi  input  1  MTHI: write wdata into HI.
- wr_lo  input  1  MTLO: write wdata into LO.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO valid from this cycle.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).
- div_zero  output  1  sticky flag: last divide had a zero divisor.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low. RST_N=0 at a rising CLK edge resets the block.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, counter=0.
- Reset has priority over every other input. Reset mid-operation aborts the operation, discards partial results, and applies the reset values at that edge.
- States:
  - IDLE: waiting for start.
  - RUN: one radix-2 iteration per edge.
  - FIN: sign fix-up and writeback.
- IDLE -> RUN on start=1:
  - Capture op, and capture ina/inb as magnitudes (absolute values for MULT/DIV, raw values for unsigned ops).
  - Record result signs.
  - Clear counter and div_zero.
  - busy=1 from this edge.
- Divide-by-zero shortcut: start with op[1]=1 and inb=0 goes IDLE -> FIN directly and sets div_zero=1. FIN then writes hi=ina (raw) and lo={WIDTH{1'b1}}.
- Multiply in RUN: shift-add on a 2*WIDTH accumulator, one multiplier bit per edge.
- Divide in RUN: restoring shift-subtract, one quotient bit per edge.
- RUN -> FIN on the edge where counter==WIDTH-1, so RUN lasts exactly WIDTH edges.
- FIN -> IDLE. On this edge:
  - Write hi/lo.
  - done=1 for exactly the following cycle.
  - busy=0 from the same edge.
- Latency: with start sampled at edge E0, hi/lo update and done rises at edge E0+WIDTH+1. For the zero-divisor case they update at E0+2.
- MULT/MULTU result: {hi,lo} = 2*WIDTH-bit product. MULT is signed and negates the magnitude product when the operand signs differ.
- DIV/DIVU result: lo=quotient, hi=remainder.
  - Signed quotient sign = sign(ina) XOR sign(inb).
  - Signed remainder sign = sign(ina).
  - Most-negative / -1 yields lo=most-negative, hi=0. There is no trap.
- start while busy=1 is ignored: no queueing and no effect on the operation in flight.
- start in the done cycle is accepted, because the state is already IDLE.
- wr_hi/wr_lo take effect at the edge only when state=IDLE and start=0. Both may be asserted together.
- wr_hi/wr_lo are ignored while busy, and ignored when start=1 in the same cycle (start has priority).
- hi/lo hold their values at all other times, including throughout RUN.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined: for MULT/MULTU, if the remaining unconsumed multiplier bits are all zero after an iteration, the unit goes RUN -> FIN at that edge. Example: inb=1 completes at E0+2.
  - The result is identical to the full run.
  - Divide latency is unchanged.
- When undefined: fixed latency of WIDTH+1 edges for every non-zero-divisor operation.

Test Plan:
- MULTU ina=0xFFFFFFFF, inb=0xFFFFFFFF (WIDTH=32) -> hi=0xFFFFFFFE, lo=0x00000001, done at E0+33, busy high E0..E0+32.
- MULT ina=0xFFFFFFFD (-3), inb=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV ina=0xFFFFFFF9 (-7), inb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU ina=100, inb=7 -> lo=14, hi=2.
- DIVU ina=0x64, inb=0 -> div_zero=1, hi=0x64, lo=0xFFFFFFFF, done at E0+2. A following valid DIV clears div_zero at its start edge.
- Pulse start again at E0+5 of a MULTU, and assert wr_lo=1 with wdata=0x1234 while busy -> both ignored; the original result is delivered at E0+33. wr_lo in IDLE -> lo=0x1234 next cycle.
- RST_N=0 at E0+10 of a DIV -> busy=0, done=0, hi=lo=0. A new start after reset behaves normally with full latency.
